// File: rtl/fc_pkg.sv
// Shared definitions for the FC load sequencer: command codes, FSM state encoding
// and the phase-ordering helpers used by the sequencer FSM.
package fc_pkg;

    localparam int FC_SIZE_W = 21;

    localparam logic [2:0] FC_CMD_IDLE = 3'd0;
    localparam logic [2:0] FC_CMD_FEAT = 3'd1;
    localparam logic [2:0] FC_CMD_BIAS = 3'd2;
    localparam logic [2:0] FC_CMD_WGT  = 3'd3;
    localparam logic [2:0] FC_CMD_RUN  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEAT,
        ST_BIAS,
        ST_WGT,
        ST_GAP,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } fc_state_t;

    // Next non-skipped phase after 'cur'; any non-load state means "from the start".
    function automatic fc_state_t fc_next_phase(input fc_state_t cur, input logic f_nz,
                                                input logic b_nz, input logic w_nz);
        fc_state_t nxt;
        nxt = ST_RUN;
        case (cur)
            ST_FEAT: begin
                if (b_nz)      nxt = ST_BIAS;
                else if (w_nz) nxt = ST_WGT;
            end
            ST_BIAS: begin
                if (w_nz) nxt = ST_WGT;
            end
            ST_WGT: nxt = ST_RUN;
            default: begin
                if (f_nz)      nxt = ST_FEAT;
                else if (b_nz) nxt = ST_BIAS;
                else if (w_nz) nxt = ST_WGT;
            end
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] fc_cmd_of(input fc_state_t s);
        case (s)
            ST_FEAT: return FC_CMD_FEAT;
            ST_BIAS: return FC_CMD_BIAS;
            ST_WGT:  return FC_CMD_WGT;
            ST_RUN:  return FC_CMD_RUN;
            default: return FC_CMD_IDLE;
        endcase
    endfunction

    function automatic logic fc_is_busy(input fc_state_t s);
        return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
    endfunction

endpackage

// File: rtl/fc_phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags expiry
// on the TIMEOUT_CYCLES-th enabled cycle.
module fc_phase_timer #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic PCLK,
    input  logic PRESETB,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = enable && !clear && (cnt == LAST);

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fc_load_sequencer.sv
// FC layer load sequencer: walks feature -> bias -> weight loads and the compute run
// from a single start pulse, with per-phase timeout, abort and cycle accounting.
module fc_load_sequencer
    import fc_pkg::*;
#(
    parameter int SIZE_W         = FC_SIZE_W,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              PCLK,
    input  logic              PRESETB,
    input  logic              start,
    input  logic              abort,
    input  logic [SIZE_W-1:0] feature_size,
    input  logic [SIZE_W-1:0] bias_size,
    input  logic [SIZE_W-1:0] weight_size,
    input  logic              feature_receive_done,
    input  logic              bias_receive_done,
    input  logic              weight_receive_done,
    input  logic              fc_done,
    input  logic [31:0]       max_index_in,
    output logic [2:0]        receiveCommand,
    output logic [SIZE_W-1:0] receive_size,
    output logic              busy,
    output logic              seq_done,
    output logic              timeout_err,
    output logic [31:0]       clk_counter,
    output logic [31:0]       max_index
);

    fc_state_t         state;
    fc_state_t         nxt;
    fc_state_t         gap_next;
    logic              first_cyc;
    logic              start_ok;
    logic              tmr_en;
    logic              expired;
    logic [SIZE_W-1:0] f_sz, b_sz, w_sz;
    logic [SIZE_W-1:0] sz_f, sz_b, sz_w;
    logic [SIZE_W-1:0] nxt_size;

    assign tmr_en = (state == ST_FEAT) || (state == ST_BIAS) ||
                    (state == ST_WGT)  || (state == ST_RUN);

    fc_phase_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .PCLK    (PCLK),
        .PRESETB (PRESETB),
        .clear   (!tmr_en),
        .enable  (tmr_en),
        .expired (expired)
    );

    // Sizes seen by the next-state logic: live inputs on the start cycle, latched otherwise.
    always_comb begin
        start_ok = start && !abort && !fc_is_busy(state);
        sz_f     = start_ok ? feature_size : f_sz;
        sz_b     = start_ok ? bias_size    : b_sz;
        sz_w     = start_ok ? weight_size  : w_sz;
        nxt      = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) nxt = fc_next_phase(ST_IDLE, |sz_f, |sz_b, |sz_w);
            end
            ST_FEAT: begin
                if (abort)                                   nxt = ST_IDLE;
                else if (!first_cyc && feature_receive_done) nxt = ST_GAP;
                else if (expired)                            nxt = ST_ERR;
            end
            ST_BIAS: begin
                if (abort)                                nxt = ST_IDLE;
                else if (!first_cyc && bias_receive_done) nxt = ST_GAP;
                else if (expired)                         nxt = ST_ERR;
            end
            ST_WGT: begin
                if (abort)                                  nxt = ST_IDLE;
                else if (!first_cyc && weight_receive_done) nxt = ST_GAP;
                else if (expired)                           nxt = ST_ERR;
            end
            ST_GAP: begin
                nxt = abort ? ST_IDLE : gap_next;
            end
            ST_RUN: begin
                if (abort)                      nxt = ST_IDLE;
                else if (!first_cyc && fc_done) nxt = ST_DONE;
                else if (expired)               nxt = ST_ERR;
            end
            default: nxt = ST_IDLE;
        endcase
        case (nxt)
            ST_FEAT: nxt_size = sz_f;
            ST_BIAS: nxt_size = sz_b;
            ST_WGT:  nxt_size = sz_w;
            default: nxt_size = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (start_ok) begin
            f_sz <= feature_size;
            b_sz <= bias_size;
            w_sz <= weight_size;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETB) begin
        if (!PRESETB) begin
            state          <= ST_IDLE;
            gap_next       <= ST_IDLE;
            first_cyc      <= 1'b0;
            receiveCommand <= FC_CMD_IDLE;
            receive_size   <= '0;
            busy           <= 1'b0;
            seq_done       <= 1'b0;
            timeout_err    <= 1'b0;
            clk_counter    <= '0;
            max_index      <= '0;
        end else begin
            state          <= nxt;
            first_cyc      <= (nxt != state);
            receiveCommand <= fc_cmd_of(nxt);
            receive_size   <= nxt_size;
            busy           <= fc_is_busy(nxt);
            seq_done       <= (nxt == ST_DONE);
            timeout_err    <= (nxt == ST_ERR);
            if (nxt == ST_GAP) begin
                gap_next <= fc_next_phase(state, |f_sz, |b_sz, |w_sz);
            end
            if (start_ok) begin
                clk_counter <= '0;
                max_index   <= '0;
            end else begin
                if (fc_is_busy(state) && clk_counter != 32'hFFFF_FFFF) begin
                    clk_counter <= clk_counter + 32'd1;
                end
                if (state == ST_RUN && nxt == ST_DONE) begin
                    max_index <= max_index_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_load_sequencer.sv
// Scoreboard bench for fc_load_sequencer: expected command/size segments are queued at
// start, a monitor pops them on every command change; a responder models the datapath.
module tb_fc_load_sequencer;

    localparam int SIZE_W = 21;
    localparam int TO     = 32;

    logic              PCLK;
    logic              PRESETB;
    logic              start, abort;
    logic [SIZE_W-1:0] feature_size, bias_size, weight_size;
    logic              feature_receive_done, bias_receive_done, weight_receive_done, fc_done;
    logic [31:0]       max_index_in;
    logic [2:0]        receiveCommand;
    logic [SIZE_W-1:0] receive_size;
    logic              busy, seq_done, timeout_err;
    logic [31:0]       clk_counter, max_index;

    fc_load_sequencer #(.SIZE_W(SIZE_W), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK                 (PCLK),
        .PRESETB              (PRESETB),
        .start                (start),
        .abort                (abort),
        .feature_size         (feature_size),
        .bias_size            (bias_size),
        .weight_size          (weight_size),
        .feature_receive_done (feature_receive_done),
        .bias_receive_done    (bias_receive_done),
        .weight_receive_done  (weight_receive_done),
        .fc_done              (fc_done),
        .max_index_in         (max_index_in),
        .receiveCommand       (receiveCommand),
        .receive_size         (receive_size),
        .busy                 (busy),
        .seq_done             (seq_done),
        .timeout_err          (timeout_err),
        .clk_counter          (clk_counter),
        .max_index            (max_index)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [2:0]        cmd;
        logic [SIZE_W-1:0] size;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    int         last_len[8];
    int         dly[5];
    logic       hold_wgt = 1'b0;
    logic [2:0] mon_prev = 3'd0;
    int         mon_len = 0;
    logic       mon_busy = 1'b0;
    logic [2:0] rc_last = 3'd0;
    int         rc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each non-empty load phase followed by a one-cycle gap, then the run
    // and the final idle command (or the idle left behind by abort/timeout when !full).
    function automatic void plan(input logic [SIZE_W-1:0] f, input logic [SIZE_W-1:0] b,
                                 input logic [SIZE_W-1:0] w, input bit full);
        logic [SIZE_W-1:0] sz[3];
        sz[0] = f; sz[1] = b; sz[2] = w;
        for (int i = 0; i < 3; i++) begin
            if (sz[i] != 0) begin
                sb.push_back('{cmd: 3'(i + 1), size: sz[i]});
                sb.push_back('{cmd: 3'd0, size: '0});
            end
        end
        if (full) begin
            sb.push_back('{cmd: 3'd4, size: '0});
            sb.push_back('{cmd: 3'd0, size: '0});
        end
    endfunction

    // Monitor: pops one expected segment whenever the command changes.
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (busy === 1'b1) busy_cnt++;
            if (receiveCommand !== mon_prev) begin
                if (mon_prev == 3'd0 && mon_busy) check("gap_len", 64'(mon_len), 64'd1);
                last_len[mon_prev] = mon_len;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got %0d expected no change", receiveCommand);
                end else begin
                    e = sb.pop_front();
                    check("cmd_seq", 64'(receiveCommand), 64'(e.cmd));
                    check("size_seq", 64'(receive_size), 64'(e.size));
                end
                mon_prev = receiveCommand;
                mon_len  = 1;
                mon_busy = busy;
            end else begin
                mon_len++;
            end
        end
    end

    // Datapath model: each done rises dly[] cycles after its command appears.
    initial begin
        feature_receive_done = 1'b0;
        bias_receive_done    = 1'b0;
        weight_receive_done  = 1'b0;
        fc_done              = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            if (receiveCommand != rc_last) rc_cyc = 1;
            else rc_cyc++;
            rc_last = receiveCommand;
            feature_receive_done = (receiveCommand == 3'd1) && (rc_cyc > dly[1]);
            bias_receive_done    = (receiveCommand == 3'd2) && (rc_cyc > dly[2]);
            weight_receive_done  = hold_wgt || ((receiveCommand == 3'd3) && (rc_cyc > dly[3]));
            fc_done              = (receiveCommand == 3'd4) && (rc_cyc > dly[4]);
        end
    end

    task automatic do_start();
        @(posedge PCLK);
        #1;
        start    = 1'b1;
        busy_cnt = 0;
        @(posedge PCLK);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic a);
        @(posedge PCLK);
        #1;
        start = s;
        abort = a;
        @(posedge PCLK);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s: got busy=1 expected busy=0 within 2000 cycles", name);
        end
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_cmd(input logic [2:0] c);
        int n = 0;
        while (receiveCommand !== c && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_cmd: got %0d expected %0d within 500 cycles", receiveCommand, c);
        end
    endtask

    task automatic set_run(input logic [SIZE_W-1:0] f, input logic [SIZE_W-1:0] b,
                           input logic [SIZE_W-1:0] w, input int d1, input int d2,
                           input int d3, input int d4, input logic [31:0] mi);
        feature_size = f; bias_size = b; weight_size = w;
        dly[1] = d1; dly[2] = d2; dly[3] = d3; dly[4] = d4;
        max_index_in = mi;
    endtask

    task automatic check_done(input string tag, input logic [31:0] mi);
        check({tag, "_seq_done"}, 64'(seq_done), 64'd1);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cmd_idle"}, 64'(receiveCommand), 64'd0);
        check({tag, "_max_index"}, 64'(max_index), 64'(mi));
        check({tag, "_clk_counter"}, 64'(clk_counter), 64'(busy_cnt));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic run_full(input string tag, input logic [SIZE_W-1:0] f,
                            input logic [SIZE_W-1:0] b, input logic [SIZE_W-1:0] w,
                            input int d1, input int d2, input int d3, input int d4,
                            input logic [31:0] mi);
        set_run(f, b, w, d1, d2, d3, d4, mi);
        plan(f, b, w, 1'b1);
        do_start();
        wait_idle({tag, "_wait"});
        check_done(tag, mi);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        PRESETB = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_run('0, '0, '0, 5, 5, 5, 10, 32'd0);
        #2 PRESETB = 1'b0;
        #1;
        check("rst_cmd", 64'(receiveCommand), 64'd0);
        check("rst_size", 64'(receive_size), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_seq_done", 64'(seq_done), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_clk_counter", 64'(clk_counter), 64'd0);
        check("rst_max_index", 64'(max_index), 64'd0);
        repeat (3) @(posedge PCLK);
        #1 PRESETB = 1'b1;

        // Basic three-phase sequence.
        run_full("s1", 21'd16, 21'd4, 21'd64, 5, 5, 5, 10, 32'd7);

        // Skipped bias phase.
        run_full("s2", 21'd16, 21'd0, 21'd64, 5, 5, 5, 10, 32'd9);

        // Stale weight done must still be masked for the first cycle.
        hold_wgt = 1'b1;
        run_full("s3", 21'd16, 21'd4, 21'd64, 5, 5, 5, 10, 32'd3);
        check("s3_wgt_len", 64'(last_len[3]), 64'd2);
        hold_wgt = 1'b0;

        // Feature done never arrives.
        set_run(21'd16, 21'd0, 21'd0, 1000, 5, 5, 10, 32'd1);
        plan(21'd16, 21'd0, 21'd0, 1'b0);
        do_start();
        wait_idle("s4_wait");
        check("s4_timeout_err", 64'(timeout_err), 64'd1);
        check("s4_seq_done", 64'(seq_done), 64'd0);
        check("s4_busy", 64'(busy), 64'd0);
        check("s4_cmd", 64'(receiveCommand), 64'd0);
        check("s4_feat_len", 64'(last_len[1]), 64'(TO));
        check("s4_clk_counter", 64'(clk_counter), 64'(TO));
        check("s4_sb_empty", 64'(sb.size()), 64'd0);

        // Abort during WGT (restart from ERR).
        set_run(21'd8, 21'd8, 21'd8, 2, 2, 30, 10, 32'd5);
        plan(21'd8, 21'd8, 21'd8, 1'b0);
        do_start();
        wait_cmd(3'd3);
        pulse(1'b0, 1'b1);
        @(negedge PCLK);
        check("s5a_busy", 64'(busy), 64'd0);
        check("s5a_cmd", 64'(receiveCommand), 64'd0);
        check("s5a_size", 64'(receive_size), 64'd0);
        check("s5a_seq_done", 64'(seq_done), 64'd0);
        check("s5a_timeout_err", 64'(timeout_err), 64'd0);
        check("s5a_clk_counter", 64'(clk_counter), 64'(busy_cnt));
        saved = clk_counter;
        repeat (3) @(negedge PCLK);
        check("s5a_clk_hold", 64'(clk_counter), 64'(saved));
        check("s5a_sb_empty", 64'(sb.size()), 64'd0);

        // Second start while busy is ignored.
        set_run(21'd8, 21'd8, 21'd8, 2, 2, 6, 4, 32'd11);
        plan(21'd8, 21'd8, 21'd8, 1'b1);
        do_start();
        wait_cmd(3'd3);
        pulse(1'b1, 1'b0);
        wait_idle("s5b_wait");
        check_done("s5b", 32'd11);

        // Start and abort together: abort wins, busy or idle.
        set_run(21'd8, 21'd8, 21'd8, 2, 2, 30, 4, 32'd11);
        plan(21'd8, 21'd8, 21'd8, 1'b0);
        do_start();
        wait_cmd(3'd3);
        pulse(1'b1, 1'b1);
        @(negedge PCLK);
        check("s5c_busy", 64'(busy), 64'd0);
        check("s5c_cmd", 64'(receiveCommand), 64'd0);
        pulse(1'b1, 1'b1);
        @(negedge PCLK);
        check("s5d_busy", 64'(busy), 64'd0);
        check("s5d_cmd", 64'(receiveCommand), 64'd0);
        check("s5d_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset during RUN, then a clean rerun.
        set_run(21'd16, 21'd4, 21'd64, 5, 5, 5, 10, 32'd7);
        plan(21'd16, 21'd4, 21'd64, 1'b1);
        do_start();
        wait_cmd(3'd4);
        @(posedge PCLK);
        #3 PRESETB = 1'b0;
        #1;
        check("s6_cmd", 64'(receiveCommand), 64'd0);
        check("s6_busy", 64'(busy), 64'd0);
        check("s6_seq_done", 64'(seq_done), 64'd0);
        check("s6_timeout_err", 64'(timeout_err), 64'd0);
        check("s6_clk_counter", 64'(clk_counter), 64'd0);
        check("s6_max_index", 64'(max_index), 64'd0);
        @(posedge PCLK);
        #1 PRESETB = 1'b1;
        @(posedge PCLK);
        #1;
        check("s6_sb_empty", 64'(sb.size()), 64'd0);
        run_full("s6_rerun", 21'd16, 21'd4, 21'd64, 5, 5, 5, 10, 32'd7);

        // Randomised sequences, including skipped phases and zero-delay dones.
        for (int i = 0; i < 15; i++) begin
            logic [SIZE_W-1:0] rf, rb, rw;
            rf = ($urandom_range(0, 3) == 0) ? '0 : SIZE_W'($urandom_range(1, 2097151));
            rb = ($urandom_range(0, 3) == 0) ? '0 : SIZE_W'($urandom_range(1, 2097151));
            rw = ($urandom_range(0, 3) == 0) ? '0 : SIZE_W'($urandom_range(1, 2097151));
            run_full("rnd", rf, rb, rw, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 12)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
